// File: rtl/data_memory_v2_pkg.sv
// Shared definitions for the byte-maskable data memory: default sizes,
// the controller state encoding and a helper for the clear-index width.
package data_memory_pkg;

    localparam int DM_DATA_WIDTH = 16;
    localparam int DM_ADDR_WIDTH = 16;
    localparam int DM_DEPTH      = 256;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dm_state_t;

    // A single-word array still needs a one-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_memory_v2_if.sv
// Request/response bundle for data_memory_v2; the requester drives the
// master side, the memory implements the slave side.
interface data_memory_v2_if
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WriteData;
    logic [DATA_WIDTH/8-1:0] ByteEnable;
    logic                    MemWrite;
    logic                    MemRead;
    logic                    Clear;
    logic                    Ready;
    logic [DATA_WIDTH-1:0]   ReadData;
    logic                    ReadValid;
    logic                    AddrError;

    modport master (
        output Address, WriteData, ByteEnable, MemWrite, MemRead, Clear,
        input  Ready, ReadData, ReadValid, AddrError
    );

    modport slave (
        input  Address, WriteData, ByteEnable, MemWrite, MemRead, Clear,
        output Ready, ReadData, ReadValid, AddrError
    );

endinterface

// File: rtl/dm_storage.sv
// Word array with one byte-masked synchronous write port and one
// synchronous read port; the read register resets, the array does not.
module dm_storage
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DM_DATA_WIDTH,
    parameter int DEPTH      = DM_DEPTH,
    parameter int IW         = idx_width(DM_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [IW-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [IW-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes into the array.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read register samples the pre-write word, giving read-before-write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_v2.sv
// Data memory controller: zero-fill sweep after reset or on request, then
// single-cycle byte-masked writes and one-cycle-latency reads.
module data_memory_v2
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DEPTH      = DM_DEPTH
) (
    input  logic             Clock,
    input  logic             Reset,
    data_memory_v2_if.slave  bus
);

    localparam int                  IW       = idx_width(DEPTH);
    localparam int                  NB       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);

    dm_state_t       state_q, state_d;
    logic [IW-1:0]   clr_idx_q, clr_idx_d;
    logic            read_valid_q, read_valid_d;
    logic            addr_error_q, addr_error_d;
    logic            zero_q, zero_d;

    logic                  in_range_s;
    logic                  mem_we_s;
    logic [NB-1:0]         mem_be_s;
    logic [IW-1:0]         mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  mem_re_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign in_range_s = ({1'b0, bus.Address} < DEPTH_L);

    // Next-state, sweep index and request decode.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        read_valid_d = 1'b0;
        addr_error_d = 1'b0;
        zero_d       = zero_q;
        mem_we_s     = 1'b0;
        mem_be_s     = '0;
        mem_waddr_s  = bus.Address[IW-1:0];
        mem_wdata_s  = bus.WriteData;
        mem_re_s     = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_be_s    = '1;
                mem_waddr_s = clr_idx_q;
                mem_wdata_s = '0;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + IW'(1);
                end
            end
            IDLE: begin
                if (bus.Clear) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (bus.MemWrite || bus.MemRead) begin
                    mem_we_s     = bus.MemWrite && in_range_s;
                    mem_be_s     = bus.ByteEnable;
                    mem_re_s     = bus.MemRead && in_range_s;
                    read_valid_d = bus.MemRead;
                    addr_error_d = !in_range_s;
                    // An out-of-range read reports zero until the next read.
                    zero_d       = bus.MemRead ? !in_range_s : zero_q;
                end else begin
                    zero_d = zero_q;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Controller state and response registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            read_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            read_valid_q <= read_valid_d;
            addr_error_q <= addr_error_d;
            zero_q       <= zero_d;
        end
    end

    dm_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_storage (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .we_i    (mem_we_s),
        .be_i    (mem_be_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .re_i    (mem_re_s),
        .raddr_i (bus.Address[IW-1:0]),
        .rdata_o (rd_data_s)
    );

    assign bus.Ready     = (state_q == IDLE);
    assign bus.ReadValid = read_valid_q;
    assign bus.AddrError = addr_error_q;
    assign bus.ReadData  = zero_q ? '0 : rd_data_s;

endmodule
